// File: rtl/ram8_banco.sv
// 8-entry register bank: one-hot demuxed writes, registered write-first read,
// and a sequencer that zeroes one entry per cycle on a clear request.
module ram8_entry #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             we,
    input  logic             clr,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)   q <= '0;
        else if (clr) q <= '0;
        else if (we)  q <= d;
    end
endmodule

module ram8_banco #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] entrada,
    input  logic [2:0]       endereco,
    input  logic             load,
    input  logic             limpar,
    output logic [WIDTH-1:0] saida,
    output logic             ocupado
);
    typedef enum logic {IDLE, CLEAR} state_t;

    state_t                 state, state_nxt;
    logic [2:0]             cnt, cnt_nxt;
    logic                   wr_en, clr_en;
    logic [7:0]             we, clr;
    logic [7:0][WIDTH-1:0]  mem;
    logic [WIDTH-1:0]       rd_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
            saida <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            saida <= rd_nxt;
        end
    end

    // A clear request in IDLE takes priority over a same-cycle write.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        wr_en     = 1'b0;
        clr_en    = 1'b0;
        case (state)
            IDLE: begin
                if (limpar) begin
                    state_nxt = CLEAR;
                    cnt_nxt   = '0;
                end else begin
                    wr_en = load;
                end
            end
            CLEAR: begin
                clr_en  = 1'b1;
                cnt_nxt = cnt + 3'd1;
                if (cnt == 3'd7) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    for (genvar k = 0; k < 8; k++) begin : g_entry
        assign we[k]  = wr_en  && (endereco == 3'(k));
        assign clr[k] = clr_en && (cnt == 3'(k));
        ram8_entry #(.WIDTH(WIDTH)) u_entry (
            .clk   (clk),
            .rst_n (rst_n),
            .we    (we[k]),
            .clr   (clr[k]),
            .d     (entrada),
            .q     (mem[k])
        );
    end

    // Write-first: forward whatever the addressed entry becomes on this edge.
    always_comb begin
        rd_nxt = mem[endereco];
        if (wr_en)                          rd_nxt = entrada;
        else if (clr_en && cnt == endereco) rd_nxt = '0;
    end

    assign ocupado = (state == CLEAR);
endmodule

// File: tb/tb_ram8_banco.sv
// Scoreboard bench for ram8_banco: a behavioural bank model pushes the expected
// outputs of each cycle, and each test pops and compares them after the edge.
module tb_ram8_banco;
    localparam int WIDTH = 16;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [WIDTH-1:0] entrada = '0;
    logic [2:0]       endereco = '0;
    logic             load = 1'b0;
    logic             limpar = 1'b0;
    logic [WIDTH-1:0] saida;
    logic             ocupado;

    ram8_banco #(.WIDTH(WIDTH)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .entrada  (entrada),
        .endereco (endereco),
        .load     (load),
        .limpar   (limpar),
        .saida    (saida),
        .ocupado  (ocupado)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [WIDTH-1:0] saida;
        logic             ocupado;
    } exp_t;

    exp_t             sb[$];
    exp_t             e;
    logic [WIDTH-1:0] mdl[8];
    logic             busy;
    int               ccnt;
    int               n_tests = 0;
    int               n_fail  = 0;

    task automatic model_reset();
        for (int i = 0; i < 8; i++) mdl[i] = '0;
        busy = 1'b0;
        ccnt = 0;
        sb.delete();
    endtask

    // Drive one cycle, update the model, push the expected post-edge outputs.
    task automatic step(input logic ld, input logic [2:0] a,
                        input logic [WIDTH-1:0] d, input logic clr);
        exp_t x;
        @(negedge clk);
        load = ld; endereco = a; entrada = d; limpar = clr;
        if (!busy) begin
            if (clr) begin
                busy = 1'b1;
                ccnt = 0;
            end else if (ld) begin
                mdl[a] = d;
            end
        end else begin
            mdl[ccnt] = '0;
            ccnt++;
            if (ccnt == 8) begin
                busy = 1'b0;
                ccnt = 0;
            end
        end
        x.saida   = mdl[a];
        x.ocupado = busy;
        @(posedge clk);
        #1;
        sb.push_back(x);
        load = 1'b0; limpar = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        model_reset();
        #2;
        n_tests++;
        if (saida !== '0 || ocupado !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: saida=%h ocupado=%b want 0/0", saida, ocupado);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 8; k++) begin
            step(1'b0, 3'(k), '0, 1'b0);
            e = sb.pop_front();
            n_tests++;
            if (saida !== 16'h0000 || ocupado !== 1'b0 || saida !== e.saida) begin
                n_fail++;
                $display("FAIL reset_read[%0d]: saida=%h ocupado=%b want 0000/0", k, saida, ocupado);
            end
        end
    endtask

    task automatic test_write_read();
        for (int k = 0; k < 8; k++) begin
            step(1'b1, 3'(k), 16'(16'h1111 * (k + 1)), 1'b0);
            e = sb.pop_front();
        end
        for (int k = 0; k < 8; k++) begin
            step(1'b0, 3'(k), 16'hFFFF, 1'b0);
            e = sb.pop_front();
            n_tests++;
            if (saida !== 16'(16'h1111 * (k + 1)) || saida !== e.saida || ocupado !== e.ocupado) begin
                n_fail++;
                $display("FAIL readback[%0d]: saida=%h want %h", k, saida, 16'(16'h1111 * (k + 1)));
            end
        end
    endtask

    task automatic test_write_first();
        step(1'b1, 3'd5, 16'hBEEF, 1'b0);
        e = sb.pop_front();
        n_tests++;
        if (saida !== 16'hBEEF || saida !== e.saida) begin
            n_fail++;
            $display("FAIL write_first: saida=%h want BEEF", saida);
        end
        step(1'b0, 3'd3, '0, 1'b0);
        e = sb.pop_front();
        n_tests++;
        if (saida !== 16'h4444 || saida !== e.saida) begin
            n_fail++;
            $display("FAIL neighbour_intact: saida=%h want 4444", saida);
        end
    endtask

    task automatic test_clear();
        // Edge N samples limpar; the model gives the 8-cycle busy window.
        step(1'b0, 3'd6, '0, 1'b1);
        for (int c = 1; c <= 9; c++) begin
            e = sb.pop_front();
            n_tests++;
            if (ocupado !== e.ocupado || saida !== e.saida) begin
                n_fail++;
                $display("FAIL clear_cycle[N+%0d]: saida=%h ocupado=%b want %h/%b",
                         c - 1, saida, ocupado, e.saida, e.ocupado);
            end
            if (c == 3) step(1'b1, 3'd7, 16'h5A5A, 1'b0);
            else        step(1'b0, 3'd6, '0, 1'b0);
        end
        e = sb.pop_front();
        n_tests++;
        if (ocupado !== 1'b0) begin
            n_fail++;
            $display("FAIL clear_done: ocupado=%b want 0", ocupado);
        end
        for (int k = 0; k < 8; k++) begin
            step(1'b0, 3'(k), '0, 1'b0);
            e = sb.pop_front();
            n_tests++;
            if (saida !== 16'h0000 || saida !== e.saida) begin
                n_fail++;
                $display("FAIL cleared[%0d]: saida=%h want 0000", k, saida);
            end
        end
    endtask

    task automatic test_clear_vs_load();
        step(1'b1, 3'd2, 16'h1234, 1'b0);
        e = sb.pop_front();
        step(1'b1, 3'd2, 16'h00AA, 1'b1);
        e = sb.pop_front();
        n_tests++;
        if (ocupado !== 1'b1 || saida !== 16'h1234 || saida !== e.saida) begin
            n_fail++;
            $display("FAIL clear_wins_edge: saida=%h ocupado=%b want 1234/1", saida, ocupado);
        end
        for (int c = 0; c < 8; c++) begin
            step(1'b0, 3'd2, '0, 1'b0);
            e = sb.pop_front();
        end
        n_tests++;
        if (saida !== 16'h0000 || ocupado !== 1'b0 || saida !== e.saida) begin
            n_fail++;
            $display("FAIL clear_wins_entry2: saida=%h ocupado=%b want 0000/0", saida, ocupado);
        end
    endtask

    task automatic test_reset_mid_clear();
        for (int k = 0; k < 8; k++) begin
            step(1'b1, 3'(k), 16'hA000 | 16'(k), 1'b0);
            e = sb.pop_front();
        end
        step(1'b0, 3'd6, '0, 1'b1);
        e = sb.pop_front();
        for (int c = 0; c < 4; c++) begin
            step(1'b0, 3'd6, '0, 1'b0);
            e = sb.pop_front();
        end
        n_tests++;
        if (saida !== 16'hA006 || ocupado !== 1'b1) begin
            n_fail++;
            $display("FAIL pre_abort: saida=%h ocupado=%b want A006/1", saida, ocupado);
        end
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        n_tests++;
        if (saida !== '0 || ocupado !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_outputs: saida=%h ocupado=%b want 0/0", saida, ocupado);
        end
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b1, 3'd4, 16'hC0DE, 1'b0);
        e = sb.pop_front();
        n_tests++;
        if (saida !== 16'hC0DE || ocupado !== 1'b0 || saida !== e.saida) begin
            n_fail++;
            $display("FAIL write_after_abort: saida=%h ocupado=%b want C0DE/0", saida, ocupado);
        end
        for (int k = 0; k < 8; k++) begin
            step(1'b0, 3'(k), '0, 1'b0);
            e = sb.pop_front();
            n_tests++;
            if (saida !== e.saida) begin
                n_fail++;
                $display("FAIL after_abort[%0d]: saida=%h want %h", k, saida, e.saida);
            end
        end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_write_first();
        test_clear();
        test_clear_vs_load();
        test_reset_mid_clear();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
